mtm_alu_scheduler: RTL and testbench
====================================

MTM_ALU_SCHEDULER -- requirements
Module: mtm_alu_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max cycles from alu_start to alu_done before abort.
REQ-002 SHALL have parameter ERR_CNT_W, default 8, meaning width of err_count.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  deserializer frame strobe, one cycle per frame.
REQ-006 SHALL have ports in_a, in_b  input  32 each  operands; in_ctl  input  8  control byte.
REQ-007 SHALL have port in_ready  output  1  high when the 1-entry input buffer is empty.
REQ-008 SHALL have ports alu_start  output  1, alu_op  output  3, alu_a, alu_b  output  32  ALU command.
REQ-009 SHALL have ports alu_done  input  1, alu_c  input  32, alu_flags  input  4  ALU result.
REQ-010 SHALL have ports out_valid  output  1, out_ready  input  1, out_data  output  32, out_ctl  output  8, out_is_data  output  1  serializer side.
REQ-011 SHALL have ports busy  output  1 (state != IDLE or buffer full) and err_count  output  ERR_CNT_W.

Function
REQ-012 SHALL capture in_a/in_b/in_ctl into the input buffer on in_valid && in_ready; in_valid while !in_ready SHALL drop the frame and increment err_count.
REQ-013 SHALL use FSM states IDLE, ISSUE, WAIT, SEND.
REQ-014 IDLE: buffer full -> classify in_ctl and free the buffer in the same cycle; in_ctl[7]==0 with legal op -> ISSUE; otherwise -> SEND with error response.
REQ-015 Legal ops (in_ctl[6:4]): 000 AND, 001 OR, 100 ADD, 101 SUB; any other op -> error out_ctl 8'b10010011.
REQ-016 in_ctl 8'b11001001 (data error) or 8'b10100101 (CRC error) SHALL be forwarded unchanged as out_ctl, out_is_data=0, out_data=0.
REQ-017 in_ctl 8'b11111111 (idle/reset frame) SHALL be discarded with no output and no err_count change; FSM stays IDLE.
REQ-018 ISSUE: alu_start high for exactly one cycle with alu_op/alu_a/alu_b from the buffered frame; -> WAIT; alu_op/alu_a/alu_b held stable until WAIT exits.
REQ-019 WAIT: timeout counter starts at 0 on entry; alu_done -> SEND with out_data=alu_c, out_ctl={1'b0, alu_flags, 3'bCRC3}, out_is_data=1, where CRC3 = CRC-3 (poly x^3+x+1, init 0) over {alu_c, 1'b0, alu_flags}.
REQ-020 WAIT: counter reaching TIMEOUT_CYCLES-1 without alu_done -> SEND with out_ctl 8'b10010011, out_is_data=0; alu_done on that same cycle SHALL take priority over timeout.
REQ-021 SEND: out_valid high, outputs stable until out_valid && out_ready; then -> IDLE; alu_done seen outside WAIT SHALL be ignored.
REQ-022 Latency: buffered legal frame to alu_start = 2 cycles; alu_done to out_valid = 1 cycle.
REQ-023 in_ready SHALL be high in the same cycle the buffer frees, allowing a back-to-back capture while FSM is in ISSUE/WAIT/SEND.
REQ-024 Every error response (REQ-015, REQ-016, REQ-020) and every dropped frame SHALL increment err_count, saturating at all-ones.

Reset
REQ-025 Asynchronous active-high rst SHALL force state IDLE, buffer empty, in_ready=1, alu_start=0, alu_op=0, alu_a=0, alu_b=0, out_valid=0, out_data=0, out_ctl=8'b11111111, out_is_data=0, busy=0, err_count=0, timeout counter=0.
REQ-026 rst asserted mid-operation SHALL abandon any in-flight frame with no output; the first frame after release SHALL be processed normally.

Structure
REQ-027 A shared package mtm_alu_pkg SHALL hold op codes, CTL error constants (11001001, 10100101, 10010011, 11111111), the FSM state enum and the CRC-3 function.
REQ-028 The timeout counter SHALL be a sub-module mtm_alu_timeout (clear, enable, expire).

Verification
REQ-029 ADD frame A=1, B=2, alu_done after 3 cycles with alu_c=3 -> one alu_start with alu_op=100, out_valid with out_data=3, out_is_data=1.
REQ-030 in_ctl=8'b10100101 -> no alu_start, out_ctl=8'b10100101, out_is_data=0, err_count 0->1.
REQ-031 op 3'b111 -> out_ctl=8'b10010011, no alu_start.
REQ-032 alu_done withheld -> after 64 cycles in WAIT out_ctl=8'b10010011; late alu_done ignored.
REQ-033 out_ready held low 10 cycles while a second frame arrives -> second frame buffered, in_ready=0, third frame dropped, err_count incremented.
REQ-034 rst pulse in WAIT -> all outputs at REQ-025 values immediately, no out_valid for the aborted frame.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg
// Shared definitions for the ALU scheduler: operation codes, control-byte
// constants for error and idle frames, the scheduler FSM state type, the
// frame classifier and the CRC-3 used to protect the ALU flags.
// No ports (package).
package mtm_alu_pkg;

   // Operation codes carried in in_ctl[6:4]
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   // Control-byte constants
   localparam logic [7:0] CTL_DATA_ERR = 8'b11001001;
   localparam logic [7:0] CTL_CRC_ERR  = 8'b10100101;
   localparam logic [7:0] CTL_OP_ERR   = 8'b10010011;
   localparam logic [7:0] CTL_IDLE     = 8'b11111111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      SEND  = 2'd3
   } state_t;

   // What the IDLE state does with a buffered frame
   typedef enum logic [1:0] {
      FR_DISCARD = 2'd0,  // idle/reset frame: dropped silently
      FR_FORWARD = 2'd1,  // upstream error byte: passed through unchanged
      FR_ERROR   = 2'd2,  // bad op or unknown command: op-error response
      FR_ISSUE   = 2'd3   // legal command: sent to the ALU
   } frame_kind_t;

   function automatic logic is_legal_op(input logic [2:0] op);
      logic legal;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB: legal = 1'b1;
         default:                       legal = 1'b0;
      endcase
      return legal;
   endfunction

   function automatic frame_kind_t classify(input logic [7:0] ctl);
      frame_kind_t kind;
      if (ctl == CTL_IDLE) begin
         kind = FR_DISCARD;
      end else if (ctl == CTL_DATA_ERR || ctl == CTL_CRC_ERR) begin
         kind = FR_FORWARD;
      end else if (!ctl[7] && is_legal_op(ctl[6:4])) begin
         kind = FR_ISSUE;
      end else begin
         kind = FR_ERROR;
      end
      return kind;
   endfunction

   // CRC-3, polynomial x^3+x+1, init 0, over {c, 1'b0, flags}, MSB first.
   // Each step multiplies the remainder by x, adds the incoming bit at x^3
   // and folds x^3 back as x+1.
   function automatic logic [2:0] crc3(input logic [31:0] c,
                                       input logic [3:0]  flags);
      logic [36:0] msg;
      logic [2:0]  crc;
      logic        fb;
      msg = {c, 1'b0, flags};
      crc = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb  = crc[2] ^ msg[i];
         crc = {crc[1], crc[0] ^ fb, fb};
      end
      return crc;
   endfunction

endpackage

// File: rtl/mtm_alu_timeout.sv
// mtm_alu_timeout
// Cycle counter bounding how long the scheduler waits for the ALU.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - synchronous clear to 0 (held while not waiting)
//   enable    - count one per cycle while high
//   expire    - high in the TIMEOUT_CYCLES-th enabled cycle after a clear
module mtm_alu_timeout #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The count parks on LAST instead of wrapping so expire cannot fall
   // back low if the owner stays enabled one cycle too long.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && cnt_q != LAST) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/mtm_alu_scheduler.sv
// mtm_alu_scheduler
// Takes deserialized frames (two operands plus a control byte), sends legal
// commands to an external ALU, and hands the result or an error response to
// the serializer.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   in_valid/in_ready             - frame strobe and 1-entry buffer empty
//   in_a, in_b, in_ctl            - frame operands and control byte
//   alu_start/alu_op/alu_a/alu_b  - one-cycle ALU command, operands held
//   alu_done/alu_c/alu_flags      - ALU result strobe, result and flags
//   out_valid/out_ready           - response handshake to serializer
//   out_data/out_ctl/out_is_data  - response payload
//   busy                          - FSM not idle or a frame is buffered
//   err_count                     - saturating error/drop counter
//
// Handshakes: in_valid is a one-cycle strobe; a frame is taken when
// in_valid && in_ready, and in_valid while !in_ready loses the frame and
// counts an error. On the output side, out_valid rises with the payload
// already in place; payload and out_valid then stay unchanged until a cycle
// with out_valid && out_ready, after which out_valid drops.
module mtm_alu_scheduler #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ERR_CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [31:0]          in_a,
   input  logic [31:0]          in_b,
   input  logic [7:0]           in_ctl,
   output logic                 in_ready,
   output logic                 alu_start,
   output logic [2:0]           alu_op,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   input  logic                 alu_done,
   input  logic [31:0]          alu_c,
   input  logic [3:0]           alu_flags,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_data,
   output logic [7:0]           out_ctl,
   output logic                 out_is_data,
   output logic                 busy,
   output logic [ERR_CNT_W-1:0] err_count
);

   import mtm_alu_pkg::*;

   state_t               state_q,       state_d;
   logic                 buf_full_q,    buf_full_d;
   logic [31:0]          buf_a_q,       buf_a_d;
   logic [31:0]          buf_b_q,       buf_b_d;
   logic [7:0]           buf_ctl_q,     buf_ctl_d;
   logic                 alu_start_q,   alu_start_d;
   logic [2:0]           alu_op_q,      alu_op_d;
   logic [31:0]          alu_a_q,       alu_a_d;
   logic [31:0]          alu_b_q,       alu_b_d;
   logic                 out_valid_q,   out_valid_d;
   logic [31:0]          out_data_q,    out_data_d;
   logic [7:0]           out_ctl_q,     out_ctl_d;
   logic                 out_is_data_q, out_is_data_d;
   logic [ERR_CNT_W-1:0] err_count_q,   err_count_d;

   logic                 buf_free;
   logic                 in_ready_w;
   logic                 drop;
   logic                 err_ev;
   logic [1:0]           err_inc;
   logic [ERR_CNT_W:0]   err_sum;
   logic                 to_clear;
   logic                 to_enable;
   logic                 to_expire;
   logic [2:0]           result_crc;

   // The buffer is emptied in the same cycle IDLE classifies it, so a new
   // frame may land on that very edge.
   assign buf_free   = (state_q == IDLE) && buf_full_q;
   assign in_ready_w = !buf_full_q || buf_free;
   assign drop       = in_valid && !in_ready_w;

   assign to_clear   = (state_q != WAIT);
   assign to_enable  = (state_q == WAIT);
   assign result_crc = crc3(alu_c, alu_flags);

   mtm_alu_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .rst   (rst),
      .clear (to_clear),
      .enable(to_enable),
      .expire(to_expire)
   );

   always_comb begin
      state_d       = state_q;
      buf_full_d    = buf_full_q;
      buf_a_d       = buf_a_q;
      buf_b_d       = buf_b_q;
      buf_ctl_d     = buf_ctl_q;
      alu_start_d   = alu_start_q;
      alu_op_d      = alu_op_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_ctl_d     = out_ctl_q;
      out_is_data_d = out_is_data_q;
      err_ev        = 1'b0;

      // Input buffer: release first, capture second, so a same-cycle
      // release and capture leaves the buffer full with the new frame.
      if (buf_free) begin
         buf_full_d = 1'b0;
      end
      if (in_valid && in_ready_w) begin
         buf_full_d = 1'b1;
         buf_a_d    = in_a;
         buf_b_d    = in_b;
         buf_ctl_d  = in_ctl;
      end

      case (state_q)
         IDLE: begin
            if (buf_full_q) begin
               case (classify(buf_ctl_q))
                  FR_ISSUE: begin
                     state_d     = ISSUE;
                     alu_start_d = 1'b1;
                     alu_op_d    = buf_ctl_q[6:4];
                     alu_a_d     = buf_a_q;
                     alu_b_d     = buf_b_q;
                  end
                  FR_FORWARD: begin
                     state_d       = SEND;
                     out_valid_d   = 1'b1;
                     out_data_d    = 32'd0;
                     out_ctl_d     = buf_ctl_q;
                     out_is_data_d = 1'b0;
                     err_ev        = 1'b1;
                  end
                  FR_ERROR: begin
                     state_d       = SEND;
                     out_valid_d   = 1'b1;
                     out_data_d    = 32'd0;
                     out_ctl_d     = CTL_OP_ERR;
                     out_is_data_d = 1'b0;
                     err_ev        = 1'b1;
                  end
                  default: begin
                     // idle/reset frame: nothing to emit
                  end
               endcase
            end
         end

         ISSUE: begin
            alu_start_d = 1'b0;
            state_d     = WAIT;
         end

         WAIT: begin
            // alu_done is tested first so a result arriving on the expiry
            // cycle still wins over the timeout.
            if (alu_done) begin
               state_d       = SEND;
               out_valid_d   = 1'b1;
               out_data_d    = alu_c;
               out_ctl_d     = {1'b0, alu_flags, result_crc};
               out_is_data_d = 1'b1;
            end else if (to_expire) begin
               state_d       = SEND;
               out_valid_d   = 1'b1;
               out_data_d    = 32'd0;
               out_ctl_d     = CTL_OP_ERR;
               out_is_data_d = 1'b0;
               err_ev        = 1'b1;
            end
         end

         SEND: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // A drop and an error response can coincide, hence a 0..2 increment.
      err_inc = {1'b0, drop} + {1'b0, err_ev};
      err_sum = {1'b0, err_count_q} + (ERR_CNT_W + 1)'(err_inc);
      if (err_sum[ERR_CNT_W]) begin
         err_count_d = '1;
      end else begin
         err_count_d = err_sum[ERR_CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         buf_full_q    <= 1'b0;
         buf_a_q       <= 32'd0;
         buf_b_q       <= 32'd0;
         buf_ctl_q     <= 8'd0;
         alu_start_q   <= 1'b0;
         alu_op_q      <= 3'd0;
         alu_a_q       <= 32'd0;
         alu_b_q       <= 32'd0;
         out_valid_q   <= 1'b0;
         out_data_q    <= 32'd0;
         out_ctl_q     <= CTL_IDLE;
         out_is_data_q <= 1'b0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         buf_full_q    <= buf_full_d;
         buf_a_q       <= buf_a_d;
         buf_b_q       <= buf_b_d;
         buf_ctl_q     <= buf_ctl_d;
         alu_start_q   <= alu_start_d;
         alu_op_q      <= alu_op_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_ctl_q     <= out_ctl_d;
         out_is_data_q <= out_is_data_d;
         err_count_q   <= err_count_d;
      end
   end

   assign in_ready    = in_ready_w;
   assign alu_start   = alu_start_q;
   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_ctl     = out_ctl_q;
   assign out_is_data = out_is_data_q;
   assign busy        = (state_q != IDLE) || buf_full_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_mtm_alu_scheduler.sv
// tb_mtm_alu_scheduler
// Scoreboard bench for mtm_alu_scheduler: directed scenarios followed by
// random frames. An ALU responder process plays the external ALU, a monitor
// pops expected responses whenever a response is handed over.
module tb_mtm_alu_scheduler;

   localparam int TO = 64;
   localparam int EW = 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [31:0]   in_a;
   logic [31:0]   in_b;
   logic [7:0]    in_ctl;
   logic          in_ready;
   logic          alu_start;
   logic [2:0]    alu_op;
   logic [31:0]   alu_a;
   logic [31:0]   alu_b;
   logic          alu_done;
   logic [31:0]   alu_c;
   logic [3:0]    alu_flags;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic [7:0]    out_ctl;
   logic          out_is_data;
   logic          busy;
   logic [EW-1:0] err_count;

   int n_checks;
   int n_pass;
   int total_err;
   logic bp_hold;

   // {chk_data, is_data, ctl[7:0], data[31:0]}
   logic [41:0] exp_q[$];
   // {op[2:0], a[31:0], b[31:0]}
   logic [66:0] cmd_q[$];
   // {expect_timeout, withhold, delay[7:0], flags[3:0], c[31:0]}
   logic [45:0] rsp_q[$];

   mtm_alu_scheduler #(
      .TIMEOUT_CYCLES(TO),
      .ERR_CNT_W     (EW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_ctl     (in_ctl),
      .in_ready   (in_ready),
      .alu_start  (alu_start),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_done   (alu_done),
      .alu_c      (alu_c),
      .alu_flags  (alu_flags),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ctl    (out_ctl),
      .out_is_data(out_is_data),
      .busy       (busy),
      .err_count  (err_count)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far",
               n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b100:  return a + b;
         3'b101:  return a - b;
         default: return 32'd0;
      endcase
   endfunction

   // Remainder of {c,0,flags}*x^3 divided by x^3+x+1 (long division).
   function automatic logic [2:0] crc_ref(input logic [31:0] c, input logic [3:0] f);
      logic [39:0] v;
      v = {c, 1'b0, f, 3'b000};
      for (int i = 39; i >= 3; i--) begin
         if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
      end
      return v[2:0];
   endfunction

   // 0 discard, 1 forward, 2 op error, 3 issue to ALU
   function automatic int frame_kind(input logic [7:0] ctl);
      if (ctl == 8'hFF) return 0;
      if (ctl == 8'hC9 || ctl == 8'hA5) return 1;
      if (!ctl[7] && (ctl[6:4] == 3'b000 || ctl[6:4] == 3'b001 ||
                      ctl[6:4] == 3'b100 || ctl[6:4] == 3'b101)) return 3;
      return 2;
   endfunction

   function automatic int err_expect();
      int lim;
      lim = (1 << EW) - 1;
      return (total_err > lim) ? lim : total_err;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_ctl   = ctl;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = $urandom();
      in_b     = $urandom();
      in_ctl   = 8'($urandom());
   endtask

   // Pushes the expected outcome, then waits for room and sends the frame.
   task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl,
                             input int delay, input logic withhold);
      int          kind;
      int          n;
      logic [3:0]  f;
      logic [31:0] c;
      logic        tmo;
      kind = frame_kind(ctl);
      f    = 4'($urandom_range(0, 15));
      case (kind)
         1: begin
            exp_q.push_back({1'b1, 1'b0, ctl, 32'd0});
            total_err++;
         end
         2: begin
            exp_q.push_back({1'b0, 1'b0, 8'b10010011, 32'd0});
            total_err++;
         end
         3: begin
            c   = alu_ref(ctl[6:4], a, b);
            tmo = withhold || (delay > TO);
            cmd_q.push_back({ctl[6:4], a, b});
            rsp_q.push_back({tmo, withhold, 8'(delay), f, c});
            if (tmo) begin
               exp_q.push_back({1'b0, 1'b0, 8'b10010011, 32'd0});
               total_err++;
            end else begin
               exp_q.push_back({1'b1, 1'b1, {1'b0, f, crc_ref(c, f)}, c});
            end
         end
         default: begin
         end
      endcase
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("in_ready wait", in_ready, 1);
      end else begin
         drive_frame(a, b, ctl);
      end
   endtask

   task automatic wait_quiet(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(exp_q.size() == 0 && cmd_q.size() == 0 && !busy && !out_valid) && n < 3000);
      chk({name, " drained"}, {exp_q.size() != 0, busy, out_valid}, 3'b000);
   endtask

   task automatic chk_err(input string name);
      chk({name, " err_count"}, err_count, err_expect());
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, " in_ready"},    in_ready,    1);
      chk({name, " alu_start"},   alu_start,   0);
      chk({name, " alu_op"},      alu_op,      0);
      chk({name, " alu_a"},       alu_a,       0);
      chk({name, " alu_b"},       alu_b,       0);
      chk({name, " out_valid"},   out_valid,   0);
      chk({name, " out_data"},    out_data,    0);
      chk({name, " out_ctl"},     out_ctl,     8'hFF);
      chk({name, " out_is_data"}, out_is_data, 0);
      chk({name, " busy"},        busy,        0);
      chk({name, " err_count"},   err_count,   0);
   endtask

   // ---------------- serializer back-pressure ----------------
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- ALU responder ----------------
   initial begin
      logic [66:0] cmd;
      logic [45:0] rsp;
      alu_done  = 1'b0;
      alu_c     = 32'd0;
      alu_flags = 4'd0;
      forever begin
         @(negedge clk);
         if (!rst && alu_start === 1'b1) begin
            if (cmd_q.size() == 0 || rsp_q.size() == 0) begin
               chk("unexpected alu_start", alu_start, 0);
            end else begin
               cmd = cmd_q.pop_front();
               rsp = rsp_q.pop_front();
               chk("alu_op", alu_op, cmd[66:64]);
               chk("alu_a",  alu_a,  cmd[63:32]);
               chk("alu_b",  alu_b,  cmd[31:0]);
               @(negedge clk);
               chk("alu_start one cycle", alu_start, 0);
               if (!rsp[44]) begin
                  repeat (int'(rsp[43:36]) - 1) @(negedge clk);
                  if (!rsp[45]) begin
                     chk("alu cmd held", {alu_op, alu_a, alu_b}, cmd);
                  end
                  alu_done  = 1'b1;
                  alu_c     = rsp[31:0];
                  alu_flags = rsp[35:32];
                  @(negedge clk);
                  alu_done  = 1'b0;
                  alu_c     = $urandom();
                  alu_flags = 4'($urandom());
                  if (!rsp[45]) begin
                     chk("alu_done to out_valid", out_valid, 1);
                  end
               end
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [41:0] e;
      logic [41:0] last;
      logic        stalled;
      stalled = 1'b0;
      last    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               chk("out stable while stalled", {out_valid, out_is_data, out_ctl, out_data}, last);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected output", out_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_ctl",     out_ctl,     e[39:32]);
                  chk("out_is_data", out_is_data, e[40]);
                  if (e[41]) chk("out_data", out_data, e[31:0]);
               end
            end
            stalled = out_valid && !out_ready;
            last    = {out_valid, out_is_data, out_ctl, out_data};
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int          n;
      int          m;
      int          r;
      logic [2:0]  op;
      logic [7:0]  ctl;
      n_checks  = 0;
      n_pass    = 0;
      total_err = 0;
      bp_hold   = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 32'd0;
      in_b      = 32'd0;
      in_ctl    = 8'd0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;

      // ADD 1+2, result after 3 cycles; alu_start two cycles after the frame
      send_frame(32'd1, 32'd2, 8'b0100_0000, 3, 1'b0);
      @(negedge clk);
      chk("latency buffer cycle alu_start", alu_start, 0);
      @(negedge clk);
      chk("latency alu_start", alu_start, 1);
      wait_quiet("add");
      chk_err("add");

      // forwarded CRC error
      send_frame($urandom(), $urandom(), 8'b10100101, 1, 1'b0);
      wait_quiet("crc err");
      chk_err("crc err");

      // illegal op 111
      send_frame($urandom(), $urandom(), 8'b0111_0110, 1, 1'b0);
      wait_quiet("op 111");
      chk_err("op 111");

      // forwarded data error and an unknown command byte
      send_frame($urandom(), $urandom(), 8'b11001001, 1, 1'b0);
      send_frame($urandom(), $urandom(), 8'b10110011, 1, 1'b0);
      wait_quiet("data err");
      chk_err("data err");

      // idle frame: discarded, no error
      send_frame($urandom(), $urandom(), 8'hFF, 1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("idle frame busy", busy, 0);
      chk_err("idle frame");

      // ALU never answers: timeout after TO cycles in WAIT, late done ignored
      send_frame(32'h0000_00F0, 32'h0000_0F00, 8'b0001_0000, 1, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!alu_start && n < 20);
      chk("timeout alu_start seen", alu_start, 1);
      m = 0;
      while (!out_valid && m < 200) begin
         @(negedge clk);
         m++;
      end
      chk("timeout length", m, TO + 1);
      wait_quiet("timeout");
      alu_done = 1'b1;
      alu_c    = 32'hDEAD_BEEF;
      @(negedge clk);
      alu_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("late done no output", {out_valid, busy}, 2'b00);
      chk_err("timeout");

      // done on the expiry cycle wins; done one cycle later is too late
      send_frame($urandom(), $urandom(), 8'b0101_0011, TO, 1'b0);
      wait_quiet("done at expiry");
      send_frame($urandom(), $urandom(), 8'b0100_1100, TO + 1, 1'b0);
      wait_quiet("done after expiry");
      chk_err("expiry");

      // serializer stalled: second frame buffered, third dropped
      bp_hold = 1'b1;
      send_frame(32'd100, 32'd23, 8'b0100_0000, 2, 1'b0);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("stall first held", out_valid, 1);
      send_frame(32'hF0F0_F0F0, 32'h0F0F_0000, 8'b0001_0000, 1, 1'b0);
      @(negedge clk);
      chk("stall in_ready", in_ready, 0);
      chk("stall busy", busy, 1);
      drive_frame(32'd7, 32'd8, 8'b0100_0000);
      total_err++;
      repeat (6) @(negedge clk);
      chk("stall out_valid", out_valid, 1);
      chk_err("drop");
      bp_hold = 1'b0;
      wait_quiet("stall");
      chk_err("stall");

      // reset while waiting on the ALU
      send_frame($urandom(), $urandom(), 8'b0101_0000, 1, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!alu_start && n < 20);
      chk("reset test alu_start seen", alu_start, 1);
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_reset_vals("mid reset");
      exp_q.delete();
      total_err = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("aborted frame silent", {out_valid, busy}, 2'b00);
      send_frame(32'd50, 32'd8, 8'b0101_1010, 2, 1'b0);
      wait_quiet("after reset");
      chk_err("after reset");

      // random traffic
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 19);
         if (r < 12) begin
            case ($urandom_range(0, 3))
               0:       op = 3'b000;
               1:       op = 3'b001;
               2:       op = 3'b100;
               default: op = 3'b101;
            endcase
            ctl = {1'b0, op, 4'($urandom())};
         end else if (r < 14) begin
            case ($urandom_range(0, 3))
               0:       op = 3'b010;
               1:       op = 3'b011;
               2:       op = 3'b110;
               default: op = 3'b111;
            endcase
            ctl = {1'b0, op, 4'($urandom())};
         end else if (r == 14) begin
            ctl = 8'hC9;
         end else if (r == 15) begin
            ctl = 8'hA5;
         end else if (r == 16) begin
            ctl = 8'hFF;
         end else begin
            ctl = {1'b1, 7'($urandom())};
         end
         send_frame($urandom(), $urandom(), ctl, $urandom_range(1, 6),
                    ($urandom_range(0, 24) == 0));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      wait_quiet("random");
      chk_err("random");
      chk("cmd queue empty", cmd_q.size(), 0);
      chk("rsp queue empty", rsp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
